// File: rtl/lcd_bus_sequencer.sv
// lcd_bus_sequencer
// Drives an 8080-style parallel display bus from single-byte command/data
// requests. Each request produces a setup / strobe / hold sequence on
// cs, rs, wr/rd and dout. A separate panel hardware-reset sequence
// (rstn low, then a wait) runs on request.
//
// Ports:
//   s_axi_aclk                 sole clock
//   rst                        synchronous reset, active-high
//   init_req                   one-cycle pulse requesting the panel reset sequence
//   cmd_valid/cmd_ready        request handshake (cmd_ready is combinational)
//   cmd_rd, cmd_rs, cmd_data   request fields: read/write, register select, write byte
//   din                        panel data bus input
//   dout, dout_oe              panel data bus output and its output enable
//   cs, rs, wr, rd, rstn       panel control lines (cs, wr, rd, rstn active-low)
//   rdata, rdata_valid         last captured read byte and its one-cycle update pulse
//   busy                       sequencer active or panel reset pending
module lcd_bus_sequencer #(
  parameter int SETUP_CYCLES    = 2,
  parameter int STROBE_CYCLES   = 3,
  parameter int HOLD_CYCLES     = 1,
  parameter int RST_LOW_CYCLES  = 200,
  parameter int RST_WAIT_CYCLES = 1000
) (
  input  logic       s_axi_aclk,
  input  logic       rst,
  input  logic       init_req,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rd,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       dout_oe,
  output logic       cs,
  output logic       rs,
  output logic       wr,
  output logic       rd,
  output logic       rstn,
  output logic [7:0] rdata,
  output logic       rdata_valid,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, RST_LO, RST_WAIT, SETUP, STROBE, HOLD} state_t;

  // Counters are loaded with N-1 on state entry; the state exits on 0.
  localparam logic [7:0]  SETUP_LOAD    = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0]  STROBE_LOAD   = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0]  HOLD_LOAD     = 8'(HOLD_CYCLES - 1);
  localparam logic [15:0] RST_LO_LOAD   = 16'(RST_LOW_CYCLES - 1);
  localparam logic [15:0] RST_WAIT_LOAD = 16'(RST_WAIT_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [7:0]  phase_cnt_reg, phase_cnt_next;
  logic [15:0] rst_cnt_reg, rst_cnt_next;
  logic        init_pending_reg, init_pending_next;
  logic        op_rd_reg, op_rd_next;
  logic        capture;
  logic        accept;
  logic        in_xfer_next;

  logic [7:0]  dout_reg, dout_next;
  logic        dout_oe_reg, dout_oe_next;
  logic        cs_reg, cs_next;
  logic        rs_reg, rs_next;
  logic        wr_reg, wr_next;
  logic        rd_reg, rd_next;
  logic        rstn_reg, rstn_next;
  logic [7:0]  rdata_reg, rdata_next;
  logic        rdata_valid_reg, rdata_valid_next;
  logic        busy_reg, busy_next;

  // init_req blocks acceptance in the same cycle so that init always wins.
  assign cmd_ready = (state_reg == IDLE) && !init_pending_reg && !init_req && !rst;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_next        = state_reg;
    phase_cnt_next    = phase_cnt_reg;
    rst_cnt_next      = rst_cnt_reg;
    init_pending_next = init_pending_reg;
    op_rd_next        = op_rd_reg;
    capture           = 1'b0;

    case (state_reg)
      IDLE: begin
        if (init_req || init_pending_reg) begin
          state_next   = RST_LO;
          rst_cnt_next = RST_LO_LOAD;
        end else if (accept) begin
          state_next     = SETUP;
          phase_cnt_next = SETUP_LOAD;
          op_rd_next     = cmd_rd;
        end
      end
      RST_LO: begin
        if (rst_cnt_reg == 16'd0) begin
          state_next   = RST_WAIT;
          rst_cnt_next = RST_WAIT_LOAD;
        end else begin
          rst_cnt_next = rst_cnt_reg - 16'd1;
        end
      end
      RST_WAIT: begin
        if (rst_cnt_reg == 16'd0) begin
          state_next        = IDLE;
          init_pending_next = 1'b0;
        end else begin
          rst_cnt_next = rst_cnt_reg - 16'd1;
        end
      end
      SETUP: begin
        if (phase_cnt_reg == 8'd0) begin
          state_next     = STROBE;
          phase_cnt_next = STROBE_LOAD;
        end else begin
          phase_cnt_next = phase_cnt_reg - 8'd1;
        end
      end
      STROBE: begin
        if (phase_cnt_reg == 8'd0) begin
          state_next     = HOLD;
          phase_cnt_next = HOLD_LOAD;
          // Sample din on the edge that ends the last strobe cycle.
          capture        = op_rd_reg;
        end else begin
          phase_cnt_next = phase_cnt_reg - 8'd1;
        end
      end
      HOLD: begin
        if (phase_cnt_reg == 8'd0) begin
          state_next = IDLE;
        end else begin
          phase_cnt_next = phase_cnt_reg - 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    // A request during a bus transaction is deferred; one during the reset
    // sequence itself is dropped.
    if (init_req && (state_reg == SETUP || state_reg == STROBE || state_reg == HOLD)) begin
      init_pending_next = 1'b1;
    end

    // Outputs are registered, so they are decoded from the next state.
    in_xfer_next     = (state_next == SETUP) || (state_next == STROBE) || (state_next == HOLD);
    cs_next          = !in_xfer_next;
    wr_next          = !((state_next == STROBE) && !op_rd_next);
    rd_next          = !((state_next == STROBE) && op_rd_next);
    rstn_next        = (state_next != RST_LO);
    dout_oe_next     = in_xfer_next && !op_rd_next;
    rs_next          = accept ? cmd_rs : rs_reg;
    dout_next        = (accept && !cmd_rd) ? cmd_data : dout_reg;
    rdata_next       = capture ? din : rdata_reg;
    rdata_valid_next = capture;
    busy_next        = (state_next != IDLE) || init_pending_next;
  end

  always_ff @(posedge s_axi_aclk) begin
    if (rst) begin
      state_reg        <= IDLE;
      phase_cnt_reg    <= 8'd0;
      rst_cnt_reg      <= 16'd0;
      init_pending_reg <= 1'b0;
      op_rd_reg        <= 1'b0;
      dout_reg         <= 8'h00;
      dout_oe_reg      <= 1'b0;
      cs_reg           <= 1'b1;
      rs_reg           <= 1'b0;
      wr_reg           <= 1'b1;
      rd_reg           <= 1'b1;
      rstn_reg         <= 1'b1;
      rdata_reg        <= 8'h00;
      rdata_valid_reg  <= 1'b0;
      busy_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      phase_cnt_reg    <= phase_cnt_next;
      rst_cnt_reg      <= rst_cnt_next;
      init_pending_reg <= init_pending_next;
      op_rd_reg        <= op_rd_next;
      dout_reg         <= dout_next;
      dout_oe_reg      <= dout_oe_next;
      cs_reg           <= cs_next;
      rs_reg           <= rs_next;
      wr_reg           <= wr_next;
      rd_reg           <= rd_next;
      rstn_reg         <= rstn_next;
      rdata_reg        <= rdata_next;
      rdata_valid_reg  <= rdata_valid_next;
      busy_reg         <= busy_next;
    end
  end

  assign dout        = dout_reg;
  assign dout_oe     = dout_oe_reg;
  assign cs          = cs_reg;
  assign rs          = rs_reg;
  assign wr          = wr_reg;
  assign rd          = rd_reg;
  assign rstn        = rstn_reg;
  assign rdata       = rdata_reg;
  assign rdata_valid = rdata_valid_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Directed testbench for lcd_bus_sequencer with S=2, P=3, H=1,
// RST_LOW=4, RST_WAIT=6. Cycle Tn is the clock period after the n-th edge
// following the accept/request cycle T0; outputs are sampled 1 time unit
// after the rising edge.
module tb_lcd_bus_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       init_req;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rd;
  logic       cmd_rs;
  logic [7:0] cmd_data;
  logic [7:0] din;
  logic [7:0] dout;
  logic       dout_oe;
  logic       cs, rs, wr, rd, rstn;
  logic [7:0] rdata;
  logic       rdata_valid;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lcd_bus_sequencer #(
    .SETUP_CYCLES(2), .STROBE_CYCLES(3), .HOLD_CYCLES(1),
    .RST_LOW_CYCLES(4), .RST_WAIT_CYCLES(6)
  ) dut (
    .s_axi_aclk(clk), .rst(rst), .init_req(init_req),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd),
    .cmd_rs(cmd_rs), .cmd_data(cmd_data), .din(din), .dout(dout),
    .dout_oe(dout_oe), .cs(cs), .rs(rs), .wr(wr), .rd(rd), .rstn(rstn),
    .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Issue a write from IDLE and check the full T0..T7 waveform; returns in T7.
  task automatic do_write(input logic [7:0] d, input logic r);
    cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_rs = r; cmd_data = d;
    #1;
    chk1("wr_ready_t0", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    for (int t = 1; t <= 7; t++) begin
      chk1("wr_cs", cs, (t <= 6) ? 1'b0 : 1'b1);
      chk1("wr_wr", wr, (t >= 3 && t <= 5) ? 1'b0 : 1'b1);
      chk1("wr_rd", rd, 1'b1);
      chk1("wr_oe", dout_oe, (t <= 6) ? 1'b1 : 1'b0);
      chk8("wr_dout", dout, d);
      chk1("wr_rs", rs, r);
      chk1("wr_busy", busy, (t <= 6) ? 1'b1 : 1'b0);
      chk1("wr_ready", cmd_ready, (t == 7) ? 1'b1 : 1'b0);
      $display("write data=%02h rs=%b T%0d cs=%b wr=%b dout=%02h", d, r, t, cs, wr, dout);
      if (t < 7) tick();
    end
  endtask

  initial begin
    rst = 1'b1; init_req = 1'b0; cmd_valid = 1'b0; cmd_rd = 1'b0;
    cmd_rs = 1'b0; cmd_data = 8'h00; din = 8'h00;

    // Reset
    repeat (3) begin
      tick();
      chk1("rst_ready", cmd_ready, 1'b0);
    end
    chk1("rst_cs", cs, 1'b1);
    chk1("rst_wr", wr, 1'b1);
    chk1("rst_rd", rd, 1'b1);
    chk1("rst_rs", rs, 1'b0);
    chk1("rst_rstn", rstn, 1'b1);
    chk8("rst_dout", dout, 8'h00);
    chk1("rst_oe", dout_oe, 1'b0);
    chk8("rst_rdata", rdata, 8'h00);
    chk1("rst_rvalid", rdata_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    rst = 1'b0;
    #1;
    chk1("rst_ready_after", cmd_ready, 1'b1);
    $display("reset done cmd_ready=%b", cmd_ready);

    // Command write 0x2C
    do_write(8'h2C, 1'b0);

    // Data read, din=0xA5 only during T5
    cmd_valid = 1'b1; cmd_rd = 1'b1; cmd_rs = 1'b1; cmd_data = 8'hFF; din = 8'h00;
    #1;
    chk1("rd_ready_t0", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    for (int t = 1; t <= 7; t++) begin
      din = (t == 5) ? 8'hA5 : 8'h00;
      chk1("rd_cs", cs, (t <= 6) ? 1'b0 : 1'b1);
      chk1("rd_rd", rd, (t >= 3 && t <= 5) ? 1'b0 : 1'b1);
      chk1("rd_wr", wr, 1'b1);
      chk1("rd_oe", dout_oe, 1'b0);
      chk1("rd_rs", rs, 1'b1);
      chk1("rd_rvalid", rdata_valid, (t == 6) ? 1'b1 : 1'b0);
      if (t >= 6) chk8("rd_rdata", rdata, 8'hA5);
      else chk8("rd_rdata_old", rdata, 8'h00);
      chk8("rd_dout_kept", dout, 8'h2C);
      $display("read T%0d cs=%b rd=%b rdata=%02h rvalid=%b", t, cs, rd, rdata, rdata_valid);
      if (t < 7) tick();
    end
    din = 8'h00;

    // Init pulse with a held write request behind it
    init_req = 1'b1;
    #1;
    chk1("init_ready_t0", cmd_ready, 1'b0);
    tick();
    init_req = 1'b0;
    cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_rs = 1'b0; cmd_data = 8'h55;
    for (int t = 1; t <= 11; t++) begin
      #1;
      chk1("init_rstn", rstn, (t <= 4) ? 1'b0 : 1'b1);
      chk1("init_cs", cs, 1'b1);
      chk1("init_busy", busy, (t <= 10) ? 1'b1 : 1'b0);
      chk1("init_ready", cmd_ready, (t == 11) ? 1'b1 : 1'b0);
      $display("init T%0d rstn=%b busy=%b cmd_ready=%b", t, rstn, busy, cmd_ready);
      if (t < 11) tick();
    end
    tick();
    cmd_valid = 1'b0;

    // Held write accepted at T11; init_req arrives at its T4
    for (int t = 1; t <= 18; t++) begin
      init_req = (t == 4) ? 1'b1 : 1'b0;
      #1;
      chk1("coll_cs", cs, (t <= 6) ? 1'b0 : 1'b1);
      chk1("coll_wr", wr, (t >= 3 && t <= 5) ? 1'b0 : 1'b1);
      chk1("coll_rstn", rstn, (t >= 8 && t <= 11) ? 1'b0 : 1'b1);
      chk1("coll_busy", busy, (t <= 17) ? 1'b1 : 1'b0);
      chk1("coll_ready", cmd_ready, (t == 18) ? 1'b1 : 1'b0);
      if (t <= 6) chk8("coll_dout", dout, 8'h55);
      $display("collision T%0d cs=%b wr=%b rstn=%b busy=%b", t, cs, wr, rstn, busy);
      if (t < 18) tick();
    end
    init_req = 1'b0;

    // init_req and cmd_valid together in IDLE: init wins
    init_req = 1'b1; cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_rs = 1'b1; cmd_data = 8'h99;
    #1;
    chk1("both_ready_t0", cmd_ready, 1'b0);
    tick();
    init_req = 1'b0; cmd_valid = 1'b0;
    for (int t = 1; t <= 11; t++) begin
      #1;
      chk1("both_rstn", rstn, (t <= 4) ? 1'b0 : 1'b1);
      chk1("both_cs", cs, 1'b1);
      chk1("both_oe", dout_oe, 1'b0);
      chk8("both_dout", dout, 8'h55);
      chk1("both_ready", cmd_ready, (t == 11) ? 1'b1 : 1'b0);
      $display("init+cmd T%0d rstn=%b cs=%b dout=%02h", t, rstn, cs, dout);
      if (t < 11) tick();
    end

    // Reset during STROBE
    cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_rs = 1'b1; cmd_data = 8'h77;
    #1;
    chk1("mid_ready_t0", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    repeat (3) tick();
    chk1("mid_wr_t4", wr, 1'b0);
    chk1("mid_cs_t4", cs, 1'b0);
    rst = 1'b1;
    tick();
    chk1("mid_wr_t5", wr, 1'b1);
    chk1("mid_cs_t5", cs, 1'b1);
    chk1("mid_busy_t5", busy, 1'b0);
    chk1("mid_oe_t5", dout_oe, 1'b0);
    chk8("mid_dout_t5", dout, 8'h00);
    chk1("mid_ready_rst", cmd_ready, 1'b0);
    $display("mid reset T5 wr=%b cs=%b busy=%b", wr, cs, busy);
    rst = 1'b0;
    #1;
    chk1("mid_ready_after", cmd_ready, 1'b1);

    // Full normal write after the abandoned one
    do_write(8'h3C, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
